// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares one common data bus (CDB) among the execution-unit groups
//   (0=ALU, 1=LD/ST, 2=MUL, 3=DIV). Each cycle at most one completed result is
//   granted and registered onto the bus, where reservation stations and the ROB
//   snoop it for operand wakeup and commit.
//
//   Build option:
//     CDB_RR_EN defined   : round-robin arbitration starting at rr_ptr.
//     CDB_RR_EN undefined : fixed priority ALU > LD/ST > MUL > DIV.
//
//   Ports:
//     clk_i         rising-edge clock
//     rst_ni        asynchronous active-low reset
//     req_valid_i   per-unit "result ready" flags
//     req_reg_id_i  per-unit destination tags, unit i at [i*TAG_W +: TAG_W]
//     req_data_i    per-unit results, unit i at [i*DATA_W +: DATA_W]
//     req_ready_o   one-hot-or-zero grant (result consumed this cycle)
//     cdb_stall_i   downstream cannot accept; hold the bus
//     flush_i       mispredict flush; drop any pending broadcast
//     cdb_valid_o   broadcast valid
//     cdb_reg_id_o  broadcast tag (0 when idle)
//     cdb_data_o    broadcast data (0 when idle)
//     grant_idx_o   unit currently on the bus (0 when idle)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*TAG_W-1:0]    req_reg_id_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic                      cdb_stall_i,
  input  logic                      flush_i,
  output logic                      cdb_valid_o,
  output logic [TAG_W-1:0]          cdb_reg_id_o,
  output logic [DATA_W-1:0]         cdb_data_o,
  output logic [IDX_W-1:0]          grant_idx_o
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;

  logic               load_en;
  logic               grant_found;
  logic [IDX_W-1:0]   grant_sel;

  logic [TAG_W-1:0]   tag_w  [N_REQ];
  logic [DATA_W-1:0]  data_w [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unit
    assign tag_w[gi]  = req_reg_id_i[gi*TAG_W +: TAG_W];
    assign data_w[gi] = req_data_i[gi*DATA_W +: DATA_W];
    // Grants are suppressed while in reset so no requester sees a transfer.
    assign req_ready_o[gi] = rst_ni && load_en && grant_found &&
                             (grant_sel == IDX_W'(gi));
  end

  // The bus can take a new result when it is free or draining this cycle;
  // a flush blocks every grant.
  assign load_en = ((state_q == ST_EMPTY) || !cdb_stall_i) && !flush_i;

`ifdef CDB_RR_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // Search upward from rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    grant_found = 1'b0;
    grant_sel   = '0;
    sum         = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ)) begin
        sum = sum - (IDX_W+1)'(N_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_sel   = cand;
      end
    end
  end

  // Pointer moves past the granted unit on every transfer, including
  // zero-tag consumes; flush and stall produce no transfer so it holds.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (load_en && grant_found) begin
      rr_ptr_d = (grant_sel == IDX_W'(N_REQ-1)) ? '0 : grant_sel + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed priority: the lowest-indexed valid unit wins.
  always_comb begin
    grant_found = 1'b0;
    grant_sel   = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        grant_found = 1'b1;
        grant_sel   = IDX_W'(k);
      end
    end
  end
`endif

  // Output register: flush clears, load replaces (or empties), otherwise hold.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    data_d  = data_q;
    gidx_d  = gidx_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      tag_d   = '0;
      data_d  = '0;
      gidx_d  = '0;
    end else if (load_en) begin
      // A zero tag is consumed but never broadcast.
      if (grant_found && (tag_w[grant_sel] != '0)) begin
        state_d = ST_FULL;
        tag_d   = tag_w[grant_sel];
        data_d  = data_w[grant_sel];
        gidx_d  = grant_sel;
      end else begin
        state_d = ST_EMPTY;
        tag_d   = '0;
        data_d  = '0;
        gidx_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      tag_q   <= '0;
      data_q  <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      gidx_q  <= gidx_d;
    end
  end

  assign cdb_valid_o  = (state_q == ST_FULL);
  assign cdb_reg_id_o = tag_q;
  assign cdb_data_o   = data_q;
  assign grant_idx_o  = gidx_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_reg_id;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            stall, flush;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_reg_id;
  logic [DW-1:0]   cdb_data;
  logic [1:0]      grant_idx;

  cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_reg_id_i (req_reg_id),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .cdb_stall_i  (stall),
    .flush_i      (flush),
    .cdb_valid_o  (cdb_valid),
    .cdb_reg_id_o (cdb_reg_id),
    .cdb_data_o   (cdb_data),
    .grant_idx_o  (grant_idx)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Results currently held by each unit.
  bit            u_v [N];
  logic [TW-1:0] u_t [N];
  logic [DW-1:0] u_d [N];
  bit            refill;   // unit re-presents the same result after a transfer

  // Reference model of the bus.
  bit            m_v;
  logic [TW-1:0] m_t;
  logic [DW-1:0] m_d;
  int            m_g;
  int            m_rr;
  int            exp_sel;
  logic [N-1:0]  exp_ready;
  int            bcast_log[$];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = u_v[i];
      req_reg_id[i*TW +: TW]  = u_t[i];
      req_data[i*DW +: DW]    = u_d[i];
    end
  endtask

  // Which unit should be granted this cycle, from the arbitration rules.
  function automatic void predict();
    bit may_load;
    may_load  = (!m_v || !stall) && !flush;
    exp_sel   = -1;
    exp_ready = '0;
    if (may_load) begin
      for (int k = 0; k < N; k++) begin
        int i;
`ifdef CDB_RR_EN
        i = (m_rr + k) % N;
`else
        i = k;
`endif
        if (exp_sel < 0 && u_v[i]) exp_sel = i;
      end
    end
    if (exp_sel >= 0) exp_ready[exp_sel] = 1'b1;
  endfunction

  task automatic model_clear();
    m_v = 0; m_t = '0; m_d = '0; m_g = 0;
  endtask

  // One cycle: starts at posedge+1, ends at the following posedge+1.
  task automatic step(string tag);
    drive();
    #1;
    predict();
    check({tag, ".ready"}, req_ready, exp_ready);
    @(posedge clk);
    if (flush) begin
      model_clear();
    end else if (!m_v || !stall) begin
      if (exp_sel >= 0 && u_t[exp_sel] != 0) begin
        m_v = 1; m_t = u_t[exp_sel]; m_d = u_d[exp_sel]; m_g = exp_sel;
      end else begin
        model_clear();
      end
    end
    if (exp_sel >= 0) begin
      m_rr = (exp_sel + 1) % N;
      if (!refill) u_v[exp_sel] = 0;
    end
    #1;
    check({tag, ".valid"}, cdb_valid, m_v);
    check({tag, ".tag"},   cdb_reg_id, m_t);
    check({tag, ".data"},  cdb_data, m_d);
    check({tag, ".gidx"},  grant_idx, m_g);
    if (cdb_valid) bcast_log.push_back(int'(cdb_reg_id));
    $display("[TB] %s ready=%b cdb v=%0d tag=%0d data=%h gidx=%0d",
             tag, exp_ready, cdb_valid, cdb_reg_id, cdb_data, grant_idx);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must drop at once.
  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", cdb_valid, 0);
    check("arst.tag",   cdb_reg_id, 0);
    check("arst.ready", req_ready, 0);
    model_clear();
    m_rr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_units();
    for (int i = 0; i < N; i++) begin
      u_v[i] = 0; u_t[i] = '0; u_d[i] = '0;
    end
  endtask

  initial begin
    int exp_seq[5];
    stall = 0; flush = 0; refill = 0;
    clear_units();
    model_clear();
    m_rr = 0;
    u_v[0] = 1; u_t[0] = 5'd3; u_d[0] = 32'h11;
    drive();

    // Reset state with ALU already requesting.
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", cdb_valid, 0);
    check("rst.ready", req_ready, 0);
    check("rst.gidx",  grant_idx, 0);
    rst_n = 1'b1;

    // First grant after release.
    step("t1");
    check("t1.tag_const",  cdb_reg_id, 3);
    check("t1.data_const", cdb_data, 32'h11);

    // Reset while FULL, then all four units valid continuously.
    reset_pulse();
    refill = 1;
    for (int i = 0; i < N; i++) begin
      u_v[i] = 1; u_t[i] = TW'(i + 1); u_d[i] = $urandom;
    end
    bcast_log.delete();
    for (int c = 0; c < 5; c++) step("t2");
`ifdef CDB_RR_EN
    exp_seq = '{1, 2, 3, 4, 1};
`else
    exp_seq = '{1, 1, 1, 1, 1};
`endif
    check("t2.count", bcast_log.size(), 5);
    for (int c = 0; c < 5 && c < bcast_log.size(); c++)
      check("t2.order", bcast_log[c], exp_seq[c]);
    refill = 0;
    clear_units();

    // FULL with tag 7, stall 3 cycles while MUL waits.
    u_v[0] = 1; u_t[0] = 5'd7; u_d[0] = 32'hCAFE0007;
    step("t3.load");
    u_v[2] = 1; u_t[2] = 5'd9; u_d[2] = 32'h00000909;
    stall = 1;
    for (int c = 0; c < 3; c++) step("t3.stall");
    check("t3.hold_tag", cdb_reg_id, 7);
    stall = 0;
    step("t3.release");
    check("t3.mul_tag", cdb_reg_id, 9);

    // DIV with zero tag: consumed, not broadcast.
    u_v[3] = 1; u_t[3] = 5'd0; u_d[3] = 32'hDEAD;
    step("t4");
    check("t4.empty", cdb_valid, 0);
    u_v[1] = 1; u_t[1] = 5'd12; u_d[1] = 32'h1212;
    step("t4.next");

    // FULL, then flush and stall together.
    u_v[0] = 1; u_t[0] = 5'd5; u_d[0] = 32'h55;
    step("t5.load");
    u_v[2] = 1; u_t[2] = 5'd6; u_d[2] = 32'h66;
    stall = 1; flush = 1;
    step("t5.flush");
    check("t5.valid0", cdb_valid, 0);
    check("t5.data0",  cdb_data, 0);
    stall = 0; flush = 0;
    step("t5.after");

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!u_v[i] && $urandom_range(0, 9) < 4) begin
          u_v[i] = 1;
          u_t[i] = ($urandom_range(0, 7) == 0) ? TW'(0) : TW'($urandom);
          u_d[i] = $urandom;
        end
      end
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) reset_pulse();
      else step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Shares one common data bus (CDB) among the execution units: ALU, load/store, multiply and divide reservation-station groups.
- Each cycle it grants at most one completed result and registers it onto the CDB. Reservation stations and the ROB snoop the bus for operand wakeup and commit.
- Replaces the per-unit broadcast buses with a single arbitrated, stallable result path.

## Interface
Parameters:
- N_REQ, 4, number of requesting units; index 0=ALU, 1=LD/ST, 2=MUL, 3=DIV
- TAG_W, 5, destination tag width; tag 0 means "no broadcast"
- DATA_W, 32, result width

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately
- req_valid  in  N_REQ  unit i holds a completed result
- req_reg_id  in  N_REQ×TAG_W  destination tag per unit
- req_data  in  N_REQ×DATA_W  result per unit
- req_ready  out  N_REQ  one-hot-or-zero grant; unit i's result is consumed this cycle
- cdb_stall  in  1  downstream (ROB) cannot accept a broadcast; hold the bus
- flush  in  1  mispredict flush; discards any pending broadcast
- cdb_valid  out  1  broadcast valid
- cdb_reg_id  out  TAG_W  broadcast tag; 0 whenever cdb_valid=0
- cdb_data  out  DATA_W  broadcast data; 0 whenever cdb_valid=0
- grant_idx  out  2  index of the unit currently on the bus; 0 when idle

## Operation
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. The unit must hold valid, tag and data stable until the transfer.
- Output register states are EMPTY (cdb_valid=0) and FULL (cdb_valid=1).
- Bus may load a new result when: (EMPTY or !cdb_stall) and !flush.
- When the bus may load, the arbiter picks one valid requester and asserts its req_ready. No other req_ready is asserted.
- Selection is round-robin: search starts at rr_ptr and proceeds upward modulo N_REQ.
- After a transfer from unit i, rr_ptr = (i+1) mod N_REQ. With no transfer, rr_ptr is unchanged.
- Zero tag: a granted request with req_reg_id==0 is consumed (ready=1) but not broadcast. The output goes EMPTY, and rr_ptr still advances.
- FULL && cdb_stall: all req_ready=0; cdb_valid, cdb_reg_id, cdb_data and grant_idx are held.
- FULL && !cdb_stall with no new grant: output returns to EMPTY.
- flush: all req_ready=0 that cycle. The output register clears to EMPTY on the next edge, overriding stall. rr_ptr is unchanged.
- The block is purely a scheduler: it performs no arithmetic and never modifies the data path.

## Timing
- Reset values: cdb_valid=0, cdb_reg_id=0, cdb_data=0, grant_idx=0, rr_ptr=0. req_ready=0 while reset is asserted.
- req_ready is combinational from req_valid, rr_ptr, cdb_valid, cdb_stall and flush; it asserts in the same cycle.
- Latency: a result accepted in cycle N appears on the CDB in cycle N+1.
- Throughput: one broadcast per cycle while !cdb_stall (back-to-back grants).
- Starvation bound: with !cdb_stall, a continuously valid requester is granted within N_REQ cycles.
- flush and cdb_stall high together: flush wins.
- Reset mid-broadcast: the bus goes EMPTY asynchronously and no result is delivered. Requesters keep their results until reset released. After release, the first grant starts at index 0.

## Configuration
- CDB_RR_EN defined: round-robin arbitration with rr_ptr, as above.
- CDB_RR_EN undefined: fixed priority ALU > LD/ST > MUL > DIV.
  - rr_ptr logic is removed.
  - The starvation bound does not apply.
  - All other behaviour is identical.

## Test plan
- Reset release, ALU valid tag 3 data 0x11: ready[0]=1 in cycle 0; next cycle cdb_valid=1, reg_id 3, data 0x11, grant_idx 0.
- All four units valid continuously (tags 1–4), CDB_RR_EN: broadcasts in order 1,2,3,4,1 on consecutive cycles. Without the macro: tag 1 repeats each cycle, since ALU remains valid.
- FULL with tag 7 and cdb_stall held for 3 cycles while MUL is valid: bus holds tag 7, req_ready=0 throughout. MUL's tag appears the cycle after stall drops.
- DIV valid with tag 0: ready[3]=1, cdb_valid stays 0, rr_ptr → 0.
- FULL, flush and cdb_stall high together: next cycle cdb_valid=0, reg_id 0, data 0; rr_ptr unchanged.
- Reset asserted asynchronously mid-cycle while FULL: cdb_valid drops to 0 before the next edge.
